// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount pipeline: the frame FSM state
// encoding, input-count clamping, and the frame-sum width calculation.
package popcount_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Upstream may deliver values above N_BITS; saturate them rather than trust them.
    function automatic logic [31:0] clamp_cnt(input logic [31:0] count, input logic [31:0] n_bits);
        return (count > n_bits) ? n_bits : count;
    endfunction

    // Smallest width that holds n_bits*frame_len, so the frame sum cannot overflow.
    function automatic int sum_width(input int n_bits, input int frame_len);
        return $clog2(n_bits * frame_len + 1);
    endfunction

endpackage

// File: rtl/popcount_frame_acc_frame_counter.sv
// Word-index counter for one frame: advances on each accepted beat,
// flags the final word of the frame, and clears synchronously.
module frame_counter #(
    parameter int FRAME_LEN = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    logic [IDX_W-1:0] idx;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign tc = (idx == IDX_W'(FRAME_LEN - 1));

endmodule

// File: rtl/popcount_frame_acc.sv
// Sums popcount results over frames of FRAME_LEN words and presents each
// frame total with a threshold flag. Optional running max: POPCOUNT_FRAME_ACC_MAX_EN.
module popcount_frame_acc
    import popcount_pkg::*;
#(
    parameter int N_BITS    = 32,
    parameter int FRAME_LEN = 16,
    parameter int THRESH    = 256,
    parameter int CNT_W     = $clog2(N_BITS + 1),
    parameter int SUM_W     = sum_width(N_BITS, FRAME_LEN)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_over
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
    ,
    output logic [CNT_W-1:0] out_max
`endif
);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] next_sum;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             tc;
    logic             last;

    assign cnt      = CNT_W'(clamp_cnt(32'(in_count), 32'(N_BITS)));
    assign next_sum = acc + SUM_W'(cnt);
    assign beat     = in_valid && in_ready;
    assign last     = beat && tc;

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk  (clk),
        .nrst (nrst),
        .clr  (last),
        .inc  (beat),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                // Held low while reset is asserted, even though reset state is ACCUM.
                in_ready = nrst;
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc      <= '0;
            out_sum  <= '0;
            out_over <= 1'b0;
        end else if (last) begin
            acc      <= '0;
            out_sum  <= next_sum;
            out_over <= (32'(next_sum) > 32'(THRESH));
        end else if (beat) begin
            acc <= next_sum;
        end
    end

`ifdef POPCOUNT_FRAME_ACC_MAX_EN
    logic [CNT_W-1:0] run_max;
    logic [CNT_W-1:0] max_nxt;

    assign max_nxt = (cnt > run_max) ? cnt : run_max;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_max <= '0;
            out_max <= '0;
        end else if (last) begin
            run_max <= '0;
            out_max <= max_nxt;
        end else if (beat) begin
            run_max <= max_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Self-checking bench for popcount_frame_acc (N_BITS=32, FRAME_LEN=4, THRESH=64):
// directed scenarios followed by random traffic against a queue-based frame model.
module tb_popcount_frame_acc;

    localparam int N_BITS    = 32;
    localparam int FRAME_LEN = 4;
    localparam int THRESH    = 64;
    localparam int CNT_W     = $clog2(N_BITS + 1);
    localparam int SUM_W     = $clog2(N_BITS * FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             nrst;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             out_over;
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
    logic [CNT_W-1:0] out_max;
`endif

    popcount_frame_acc #(
        .N_BITS    (N_BITS),
        .FRAME_LEN (FRAME_LEN),
        .THRESH    (THRESH)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_over  (out_over)
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
        ,
        .out_max   (out_max)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the accepted counts of the current frame, plus the
    // result that should be on the output port.
    int q[$];
    bit m_hold;
    int m_sum;
    bit m_over;
    int m_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hold = 1'b0;
        m_sum  = 0;
        m_over = 1'b0;
        m_max  = 0;
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(!m_hold));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("out_sum", 32'(out_sum), m_sum);
        check("out_over", 32'(out_over), 32'(m_over));
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
        check("out_max", 32'(out_max), m_max);
`endif
    endtask

    // Called at a falling edge: drive inputs, check outputs, predict the coming edge.
    task automatic step(input bit v, input int c, input bit r);
        int s;
        int mx;
        in_valid  = v;
        in_count  = CNT_W'(c);
        out_ready = r;
        #1;
        check_outputs();
        if (!m_hold && v) begin
            q.push_back((c > N_BITS) ? N_BITS : c);
            if (q.size() == FRAME_LEN) begin
                s  = 0;
                mx = 0;
                foreach (q[i]) begin
                    s += q[i];
                    if (q[i] > mx) mx = q[i];
                end
                m_sum  = s;
                m_over = (s > THRESH);
                m_max  = mx;
                m_hold = 1'b1;
                q.delete();
            end
        end else if (m_hold && r) begin
            m_hold = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sum"}, 32'(out_sum), 0);
        check({tag, "_out_over"}, 32'(out_over), 0);
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
        check({tag, "_out_max"}, 32'(out_max), 0);
`endif
    endtask

    initial begin
        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");
        nrst = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 1);
        @(negedge clk);

        // Back-to-back frame, consumer always ready.
        step(1, 1, 1); step(1, 2, 1); step(1, 3, 1); step(1, 4, 1);
        check("f1_sum", 32'(out_sum), 10);
        check("f1_over", 32'(out_over), 0);
        check("f1_valid", 32'(out_valid), 1);
        step(0, 0, 1);
        check("f1_valid_one_cycle", 32'(out_valid), 0);
        check("f1_ready_back", 32'(in_ready), 1);
        step(0, 0, 1);

        // Threshold boundary: one above, then exactly at.
        step(1, 32, 1); step(1, 32, 1); step(1, 1, 1); step(1, 0, 1);
        check("f2_sum", 32'(out_sum), 65);
        check("f2_over", 32'(out_over), 1);
        step(0, 0, 1);
        step(1, 32, 1); step(1, 32, 1); step(1, 0, 1); step(1, 0, 1);
        check("f3_sum", 32'(out_sum), 64);
        check("f3_over", 32'(out_over), 0);
        step(0, 0, 1);

        // Back-pressure with in_valid held high through HOLD.
        step(1, 1, 1); step(1, 1, 1); step(1, 1, 1); step(1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low", 32'(in_ready), 0);
            check("bp_sum_stable", 32'(out_sum), 4);
            step(1, 7, 0);
        end
        step(1, 7, 1);
        step(1, 2, 1); step(1, 2, 1); step(1, 2, 1); step(1, 2, 1);
        check("bp_next_sum", 32'(out_sum), 8);
        step(0, 0, 1);

        // in_valid gaps stall the index.
        for (int i = 0; i < 4; i++) begin
            step(1, 5, 1);
            if (i < 3) begin
                check("gap_no_valid", 32'(out_valid), 0);
                step(0, 9, 1);
            end
        end
        check("gap_sum", 32'(out_sum), 20);
        step(0, 0, 1);

        // Out-of-range count is clamped.
        step(1, 40, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        check("clamp_sum", 32'(out_sum), 32);
`ifdef POPCOUNT_FRAME_ACC_MAX_EN
        check("clamp_max", 32'(out_max), 32);
`endif
        step(0, 0, 1);

        // Reset mid-frame discards the partial sum.
        step(1, 10, 1); step(1, 10, 1);
        nrst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step(1, 1, 1); step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
        check("after_reset_sum", 32'(out_sum), 4);
        step(0, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 40)), ($urandom_range(0, 2) != 0));
        end

        // Reset while a result is pending.
        while (!m_hold) step(1, int'($urandom_range(0, 40)), 0);
        nrst = 1'b0;
        #1;
        check_reset_values("hold_reset");
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
